// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver.
// Segment vectors are ordered {a,b,c,d,e,f,g} and are active-high (1 = lit).
// Polarity inversion for the pins happens only in the output stage of the top.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b0011111;
  localparam seg_t SEG_C     = 7'b1001110;
  localparam seg_t SEG_D     = 7'b0111101;
  localparam seg_t SEG_E     = 7'b1001111;
  localparam seg_t SEG_F     = 7'b1000111;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to 7-segment decoder, active-high {a..g}.
// Ports:
//   nibble_i   - 4-bit value to display
//   hex_mode_i - 1: 10..15 show A,b,C,d,E,F; 0: 10..15 are blank
//   seg_o      - decoded segment vector (1 = lit)
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_mode_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0:    seg_o = SEG_0;
      4'h1:    seg_o = SEG_1;
      4'h2:    seg_o = SEG_2;
      4'h3:    seg_o = SEG_3;
      4'h4:    seg_o = SEG_4;
      4'h5:    seg_o = SEG_5;
      4'h6:    seg_o = SEG_6;
      4'h7:    seg_o = SEG_7;
      4'h8:    seg_o = SEG_8;
      4'h9:    seg_o = SEG_9;
      4'hA:    seg_o = hex_mode_i ? SEG_A : SEG_BLANK;
      4'hB:    seg_o = hex_mode_i ? SEG_B : SEG_BLANK;
      4'hC:    seg_o = hex_mode_i ? SEG_C : SEG_BLANK;
      4'hD:    seg_o = hex_mode_i ? SEG_D : SEG_BLANK;
      4'hE:    seg_o = hex_mode_i ? SEG_E : SEG_BLANK;
      4'hF:    seg_o = hex_mode_i ? SEG_F : SEG_BLANK;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed driver for NUM_DIGITS 7-segment digits sharing one segment bus.
// Each digit owns a slot of REFRESH_CYCLES clocks; the first DEAD_CYCLES of every
// slot keep all digits dark to avoid ghosting. New values are double-buffered and
// only become visible at a frame boundary, so a frame never mixes old and new data.
// Ports:
//   clk         - system clock
//   reset       - synchronous, active-high reset
//   load        - strobe capturing digits_in/blank_in
//   digits_in   - nibble i at [4i+3:4i] drives digit i
//   blank_in    - bit i forces digit i dark
//   seg         - {a..g}, polarity per SEG_ACTIVE_LOW (registered)
//   anode       - one-hot digit enable, polarity per DIG_ACTIVE_LOW (registered)
//   frame_start - one-cycle pulse when slot 0 begins (registered)
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 2,
  parameter int unsigned REFRESH_CYCLES = 50000,
  parameter int unsigned DEAD_CYCLES    = 500,
  parameter int unsigned HEX_MODE       = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_start
);

  localparam int unsigned CntW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_CYCLES - 1);
  localparam logic [CntW-1:0] CntDead = CntW'(DEAD_CYCLES);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

  localparam logic [6:0]            SegOff = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DigOff = {NUM_DIGITS{(DIG_ACTIVE_LOW != 0)}};

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic                    frame_start_q, frame_start_d;

  logic       slot_wrap;
  logic       boundary;
  logic       dead;
  logic [3:0] cur_nibble;
  logic       cur_blank;
  logic [6:0] dec_seg;
  logic [6:0] seg_logic;
  logic [NUM_DIGITS-1:0] anode_logic;

  // Slot / digit counters.
  always_comb begin
    slot_wrap = (cnt_q == CntLast);
    boundary  = slot_wrap && (idx_q == IdxLast);
    cnt_d     = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  // Double buffer: loads land in pending; active only changes on a frame boundary.
  // A load coinciding with the boundary bypasses pending and discards it.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_blank_d = pend_blank_q;
    pend_valid_d = pend_valid_q;
    act_val_d    = act_val_q;
    act_blank_d  = act_blank_q;
    if (boundary) begin
      if (load) begin
        act_val_d    = digits_in;
        act_blank_d  = blank_in;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        act_val_d    = pend_val_q;
        act_blank_d  = pend_blank_q;
        pend_valid_d = 1'b0;
      end
    end else if (load) begin
      pend_val_d   = digits_in;
      pend_blank_d = blank_in;
      pend_valid_d = 1'b1;
    end
  end

  // Select the active digit and its enable.
  always_comb begin
    cur_nibble  = 4'h0;
    cur_blank   = 1'b1;
    anode_logic = '0;
    dead        = (cnt_q < CntDead);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nibble     = act_val_q[4*i +: 4];
        cur_blank      = act_blank_q[i];
        anode_logic[i] = !dead;
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble_i   (cur_nibble),
    .hex_mode_i (HEX_MODE != 0),
    .seg_o      (dec_seg)
  );

  // Output stage: blanking, then pin polarity.
  always_comb begin
    seg_logic     = (dead || cur_blank) ? SEG_BLANK : dec_seg;
    seg_d         = (SEG_ACTIVE_LOW != 0) ? ~seg_logic : seg_logic;
    anode_d       = (DIG_ACTIVE_LOW != 0) ? ~anode_logic : anode_logic;
    frame_start_d = (cnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      pend_val_q    <= '0;
      pend_blank_q  <= '0;
      pend_valid_q  <= 1'b0;
      act_val_q     <= '0;
      act_blank_q   <= '1;
      seg_q         <= SegOff;
      anode_q       <= DigOff;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pend_val_q    <= pend_val_d;
      pend_blank_q  <= pend_blank_d;
      pend_valid_q  <= pend_valid_d;
      act_val_q     <= act_val_d;
      act_blank_q   <= act_blank_d;
      seg_q         <= seg_d;
      anode_q       <= anode_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign anode       = anode_q;
  assign frame_start = frame_start_q;

endmodule
